// File: rtl/bn_bwd_sched_if.sv
// Requester, engine and response signals of the batch-norm backward scheduler.
// The master modport is the scheduler; slave is the requester/engine side.
interface bn_bwd_sched_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IL   = 4,
  parameter int unsigned FL   = 16
);
  logic [NREQ-1:0]             req;
  logic [NREQ-1:0][4:0]        req_num;
  logic [NREQ-1:0]             resp_ack;
  logic [NREQ-1:0]             grant;
  logic                        eng_input_ready;
  logic                        eng_output_taken;
  logic [4:0]                  eng_num;
  logic                        eng_done;
  logic signed [IL+FL-1:0]     eng_dgamma;
  logic signed [IL+FL-1:0]     eng_dbeta;
  logic [NREQ-1:0]             resp_valid;
  logic signed [IL+FL-1:0]     resp_dgamma;
  logic signed [IL+FL-1:0]     resp_dbeta;
  logic                        resp_err;
  logic                        busy;
  logic [15:0]                 jobs_done;

  modport master (
    input  req, req_num, resp_ack, eng_done, eng_dgamma, eng_dbeta,
    output grant, eng_input_ready, eng_output_taken, eng_num, resp_valid,
           resp_dgamma, resp_dbeta, resp_err, busy, jobs_done
  );

  modport slave (
    output req, req_num, resp_ack, eng_done, eng_dgamma, eng_dbeta,
    input  grant, eng_input_ready, eng_output_taken, eng_num, resp_valid,
           resp_dgamma, resp_dbeta, resp_err, busy, jobs_done
  );
endinterface

// File: rtl/bn_bwd_sched.sv
// Round-robin scheduler sharing one batch-norm backward engine among NREQ requesters,
// with batch-size rejection, busy timeout and held one-hot responses.
module bn_bwd_sched #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned IL      = 4,
  parameter int unsigned FL      = 16,
  parameter int unsigned SIZE    = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            reset,
  bn_bwd_sched_if.master  bus
);
  localparam int unsigned W   = IL + FL;
  localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned TW  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {StIdle, StLaunch, StBusy, StResp, StReject} state_e;

  state_e              r_state;
  logic [IDW-1:0]      r_ptr;
  logic [IDW-1:0]      r_id;
  logic [TW-1:0]       r_timer;
  logic [NREQ-1:0]     r_grant;
  logic [NREQ-1:0]     r_valid;
  logic                r_err;
  logic signed [W-1:0] r_dgamma;
  logic signed [W-1:0] r_dbeta;
  logic [4:0]          r_num;
  logic [15:0]         r_jobs;
  logic                r_in_rdy;
  logic                r_out_taken;

  logic                w_found;
  logic [IDW-1:0]      w_idx;
  logic [IDW-1:0]      w_sel;
  logic [4:0]          w_sel_num;
  logic                w_bad;

  // Search starts one past the last served requester.
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    w_sel   = '0;
    for (int i = 1; i <= int'(NREQ); i++) begin
      w_idx = IDW'((int'(r_ptr) + i) % int'(NREQ));
      if (!w_found && bus.req[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
    end
    w_sel_num = bus.req_num[w_sel];
    w_bad     = (w_sel_num == 5'd0) || (32'(w_sel_num) > SIZE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= StIdle;
      r_ptr       <= IDW'(NREQ - 1);
      r_id        <= '0;
      r_timer     <= '0;
      r_grant     <= '0;
      r_valid     <= '0;
      r_err       <= 1'b0;
      r_dgamma    <= '0;
      r_dbeta     <= '0;
      r_num       <= '0;
      r_jobs      <= '0;
      r_in_rdy    <= 1'b0;
      r_out_taken <= 1'b0;
    end else begin
      r_in_rdy    <= 1'b0;
      r_out_taken <= 1'b0;
      case (r_state)
        StIdle: begin
          if (w_found) begin
            r_id    <= w_sel;
            r_num   <= w_sel_num;
            r_grant <= NREQ'(1) << w_sel;
            if (w_bad) begin
              r_state <= StReject;
            end else begin
              r_state  <= StLaunch;
              r_in_rdy <= 1'b1;
            end
          end
        end
        StLaunch: begin
          r_timer <= '0;
          r_state <= StBusy;
        end
        StBusy: begin
          // Completion wins over a timeout landing in the same cycle.
          if (bus.eng_done) begin
            r_dgamma    <= bus.eng_dgamma;
            r_dbeta     <= bus.eng_dbeta;
            r_err       <= 1'b0;
            r_out_taken <= 1'b1;
            r_valid     <= r_grant;
            r_state     <= StResp;
          end else if (r_timer == TW'(TIMEOUT - 1)) begin
            r_dgamma    <= '0;
            r_dbeta     <= '0;
            r_err       <= 1'b1;
            r_out_taken <= 1'b1;
            r_valid     <= r_grant;
            r_state     <= StResp;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        StReject: begin
          r_dgamma <= '0;
          r_dbeta  <= '0;
          r_err    <= 1'b1;
          r_valid  <= r_grant;
          r_state  <= StResp;
        end
        StResp: begin
          if (bus.resp_ack[r_id]) begin
            r_valid <= '0;
            r_grant <= '0;
            r_ptr   <= r_id;
            if (!r_err && (r_jobs != 16'hFFFF)) r_jobs <= r_jobs + 16'd1;
            r_err   <= 1'b0;
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.grant            = r_grant;
  assign bus.eng_input_ready  = r_in_rdy;
  assign bus.eng_output_taken = r_out_taken;
  assign bus.eng_num          = r_num;
  assign bus.resp_valid       = r_valid;
  assign bus.resp_dgamma      = r_dgamma;
  assign bus.resp_dbeta       = r_dbeta;
  assign bus.resp_err         = r_err;
  assign bus.busy             = (r_state != StIdle);
  assign bus.jobs_done        = r_jobs;
endmodule

// File: tb/tb_bn_bwd_sched.sv
// Directed bench for bn_bwd_sched: one engine job at a time, expected values hand-derived.
module tb_bn_bwd_sched;
  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_rdy    = 0;
  int   n_both   = 0;
  int   n_wait;
  logic [3:0] exp_rr [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  always #5 clk = ~clk;

  bn_bwd_sched_if #(.NREQ(4), .IL(4), .FL(16)) bus ();

  bn_bwd_sched #(
    .NREQ(4), .IL(4), .FL(16), .SIZE(16), .TIMEOUT(255)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.eng_input_ready) n_rdy++;
    if (bus.eng_input_ready && bus.eng_output_taken) n_both++;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_taken(output int n);
    n = 0;
    while (!bus.eng_output_taken && n < 400) begin
      tick();
      n++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    bus.req        = '0;
    bus.req_num    = '0;
    bus.resp_ack   = '0;
    bus.eng_done   = 1'b0;
    bus.eng_dgamma = '0;
    bus.eng_dbeta  = '0;
    do_reset();

    check("rst_grant", bus.grant, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_valid", bus.resp_valid, 0);
    check("rst_jobs", bus.jobs_done, 0);
    check("rst_num", bus.eng_num, 0);
    check("rst_pulses", {bus.eng_input_ready, bus.eng_output_taken, bus.resp_err}, 0);

    // Single job on requester 0, engine finishes 20 cycles after start.
    n_rdy = 0;
    bus.req = 4'b0001;
    bus.req_num[0] = 5'd8;
    tick();
    check("j1_grant", bus.grant, 4'b0001);
    check("j1_ready", bus.eng_input_ready, 1);
    check("j1_num", bus.eng_num, 8);
    bus.req = 4'b0000;
    tick();
    check("j1_ready_off", bus.eng_input_ready, 0);
    check("j1_busy", bus.busy, 1);
    for (int k = 0; k < 18; k++) tick();
    bus.eng_done   = 1'b1;
    bus.eng_dgamma = 20'h01000;
    bus.eng_dbeta  = 20'h00abc;
    tick();
    bus.eng_done = 1'b0;
    check("j1_taken", bus.eng_output_taken, 1);
    check("j1_valid", bus.resp_valid, 4'b0001);
    check("j1_dgamma", {12'd0, bus.resp_dgamma}, 32'h01000);
    check("j1_dbeta", {12'd0, bus.resp_dbeta}, 32'h00abc);
    check("j1_err", bus.resp_err, 0);
    bus.eng_dgamma = 20'h0;
    tick();
    tick();
    check("j1_taken_off", bus.eng_output_taken, 0);
    check("j1_hold", {12'd0, bus.resp_dgamma}, 32'h01000);
    check("j1_rdy_count", n_rdy, 1);
    bus.resp_ack = 4'b0001;
    tick();
    bus.resp_ack = 4'b0000;
    check("j1_ack_valid", bus.resp_valid, 0);
    check("j1_ack_grant", bus.grant, 0);
    check("j1_ack_busy", bus.busy, 0);
    check("j1_jobs", bus.jobs_done, 1);

    // Round robin with all requesters held, acked 2 cycles after resp_valid.
    do_reset();
    bus.req = 4'b1111;
    for (int j = 0; j < 4; j++) bus.req_num[j] = 5'd3;
    for (int j = 0; j < 5; j++) begin
      tick();
      check("rr_grant", bus.grant, exp_rr[j]);
      tick();
      bus.eng_done   = 1'b1;
      bus.eng_dgamma = 20'(j + 1);
      tick();
      bus.eng_done = 1'b0;
      check("rr_valid", bus.resp_valid, exp_rr[j]);
      check("rr_dgamma", {12'd0, bus.resp_dgamma}, 32'(j + 1));
      tick();
      tick();
      check("rr_grant_hold", bus.grant, exp_rr[j]);
      bus.resp_ack = exp_rr[j];
      if (j == 4) bus.req = 4'b0000;
      tick();
      bus.resp_ack = 4'b0000;
      check("rr_idle", bus.busy, 0);
    end
    check("rr_jobs", bus.jobs_done, 5);

    // Zero-size batch is rejected without starting the engine.
    n_rdy = 0;
    bus.req = 4'b0100;
    bus.req_num[2] = 5'd0;
    tick();
    bus.req = 4'b0000;
    check("rej0_grant", bus.grant, 4'b0100);
    check("rej0_valid_early", bus.resp_valid, 0);
    tick();
    check("rej0_valid", bus.resp_valid, 4'b0100);
    check("rej0_err", bus.resp_err, 1);
    check("rej0_dgamma", {12'd0, bus.resp_dgamma}, 0);
    bus.resp_ack = 4'b0100;
    tick();
    bus.resp_ack = 4'b0000;
    check("rej0_no_ready", n_rdy, 0);
    check("rej0_jobs", bus.jobs_done, 5);

    // One past the maximum batch size is rejected too.
    bus.req = 4'b1000;
    bus.req_num[3] = 5'd17;
    tick();
    bus.req = 4'b0000;
    tick();
    check("rej17_err", bus.resp_err, 1);
    check("rej17_valid", bus.resp_valid, 4'b1000);
    bus.resp_ack = 4'b1000;
    tick();
    bus.resp_ack = 4'b0000;
    check("rej17_no_ready", n_rdy, 0);

    // Maximum batch size is accepted; engine never finishes, so it times out.
    bus.req = 4'b0001;
    bus.req_num[0] = 5'd16;
    tick();
    bus.req = 4'b0000;
    check("to_ready", bus.eng_input_ready, 1);
    check("to_num", bus.eng_num, 16);
    tick();
    wait_taken(n_wait);
    check("to_cycles", n_wait, 255);
    check("to_err", bus.resp_err, 1);
    check("to_valid", bus.resp_valid, 4'b0001);
    check("to_dgamma", {12'd0, bus.resp_dgamma}, 0);
    check("to_dbeta", {12'd0, bus.resp_dbeta}, 0);
    bus.resp_ack = 4'b0001;
    tick();
    bus.resp_ack = 4'b0000;
    check("to_jobs", bus.jobs_done, 5);

    // Completion in the timeout cycle counts as success; wrong-index ack ignored.
    bus.req = 4'b0010;
    bus.req_num[1] = 5'd5;
    tick();
    bus.req = 4'b0000;
    tick();
    for (int k = 0; k < 254; k++) tick();
    check("edge_still_busy", bus.eng_output_taken, 0);
    bus.eng_done   = 1'b1;
    bus.eng_dgamma = 20'h00abc;
    bus.eng_dbeta  = 20'h12345;
    tick();
    bus.eng_done = 1'b0;
    check("edge_taken", bus.eng_output_taken, 1);
    check("edge_err", bus.resp_err, 0);
    check("edge_dgamma", {12'd0, bus.resp_dgamma}, 32'h00abc);
    check("edge_dbeta", {12'd0, bus.resp_dbeta}, 32'h12345);
    bus.resp_ack = 4'b0001;
    tick();
    tick();
    check("wrong_ack_valid", bus.resp_valid, 4'b0010);
    check("wrong_ack_busy", bus.busy, 1);
    bus.resp_ack = 4'b0010;
    tick();
    bus.resp_ack = 4'b0000;
    check("edge_jobs", bus.jobs_done, 6);

    // Reset in BUSY abandons the job silently; the next job runs normally.
    bus.req = 4'b0010;
    bus.req_num[1] = 5'd4;
    tick();
    bus.req = 4'b0000;
    tick();
    check("rb_busy_pre", bus.busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rb_grant", bus.grant, 0);
    check("rb_busy", bus.busy, 0);
    check("rb_pulses", {bus.eng_input_ready, bus.eng_output_taken}, 0);
    check("rb_valid", bus.resp_valid, 0);
    bus.req = 4'b0010;
    tick();
    bus.req = 4'b0000;
    check("rb2_grant", bus.grant, 4'b0010);
    check("rb2_ready", bus.eng_input_ready, 1);
    tick();
    bus.eng_done   = 1'b1;
    bus.eng_dgamma = 20'h00077;
    tick();
    bus.eng_done = 1'b0;
    check("rb2_valid", bus.resp_valid, 4'b0010);
    check("rb2_dgamma", {12'd0, bus.resp_dgamma}, 32'h00077);
    bus.resp_ack = 4'b0010;
    tick();
    bus.resp_ack = 4'b0000;
    check("rb2_jobs", bus.jobs_done, 1);

    check("pulse_overlap", n_both, 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/bn_bwd_sched.md
BN_BWD_SCHED -- requirements
Module: bn_bwd_sched

Interface
REQ-001 Parameters (name, default, meaning):
- NREQ, 4, number of requesters
- IL, 4, integer bits
- FL, 16, fraction bits
- SIZE, 16, maximum batch size
- TIMEOUT, 255, maximum number of engine busy cycles
REQ-002 Clock/reset: reset is synchronous, active-high; the clock is clk.
REQ-003 Ports (name, direction, width, meaning):
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req  in  NREQ  per-requester job request (level)
- req_num  in  NREQ x 5  per-requester batch count
- resp_ack  in  NREQ  per-requester result acknowledge
- grant  out  NREQ  one-hot select for the engine input mux
- eng_input_ready  out  1  engine start pulse
- eng_output_taken  out  1  engine release pulse
- eng_num  out  5  latched batch count driven to the engine
- eng_done  in  1  engine completion
- eng_dgamma, eng_dbeta  in  IL+FL each  engine results, signed
- resp_valid  out  NREQ  result valid, one-hot
- resp_dgamma, resp_dbeta  out  IL+FL each  held results
- resp_err  out  1  job rejected or timed out
- busy  out  1  scheduler not IDLE
- jobs_done  out  16  completed-job counter

Function
REQ-004 The FSM SHALL have five states: IDLE, LAUNCH, BUSY, RESP, REJECT.
REQ-005 In IDLE with any req high, the scheduler SHALL select one requester round-robin, starting the search at ptr+1 mod NREQ.
- On selection it latches the id, latches req_num[id] into eng_num, and asserts grant one-hot on the next cycle.
REQ-006 A latched num of 0 or greater than SIZE SHALL go to REJECT instead of LAUNCH. The engine is never started for that job.
REQ-007 LAUNCH SHALL assert eng_input_ready for exactly one cycle, then enter BUSY with the timer cleared.
REQ-008 In BUSY, the timer SHALL increment each cycle.
- On eng_done high, eng_dgamma and eng_dbeta are registered into resp_dgamma and resp_dbeta.
- eng_output_taken is pulsed for one cycle, and the FSM enters RESP with resp_err=0.
REQ-009 If the timer reaches TIMEOUT without eng_done, the scheduler SHALL pulse eng_output_taken, clear the results to 0, set resp_err=1 and enter RESP.
REQ-010 eng_done arriving in the same cycle as the timeout SHALL be treated as success.
REQ-011 REJECT SHALL clear the results, set resp_err=1 and enter RESP on the next cycle.
REQ-012 In RESP, resp_valid[id] SHALL stay high and the results SHALL stay stable until resp_ack[id] is high.
- resp_ack on any other index is ignored.
REQ-013 On the acknowledge cycle, the scheduler SHALL:
- deassert resp_valid and grant
- set ptr=id
- increment jobs_done (saturating at 0xFFFF) only if resp_err=0
- clear resp_err
- return to IDLE
REQ-014 A requester SHALL be eligible again no earlier than the first IDLE cycle after its acknowledge. req deassertion mid-job does not abort the job.
REQ-015 grant SHALL stay constant from LAUNCH through RESP. It is 0 in IDLE.
REQ-016 busy SHALL be 1 in every state except IDLE.
REQ-017 eng_input_ready and eng_output_taken SHALL never be high in the same cycle.
REQ-018 The result registers SHALL be full IL+FL signed width. No arithmetic is applied to them, only capture.

Reset
REQ-019 With reset high, the following SHALL take effect on the next clk edge:
- state=IDLE and ptr=NREQ-1, so requester 0 has first priority
- timer, grant, resp_valid, resp_err, results, eng_num and jobs_done = 0
- no engine pulses
REQ-020 Reset asserted in any state SHALL abandon the current job with no response and no pulse.
- The engine's own reset is expected to clear it.

Verification
REQ-021 req=0001, num=8, eng_done 20 cycles after start, dgamma=0x01000 -> grant=0001, one eng_input_ready pulse, resp_valid[0] with dgamma=0x01000; after ack, jobs_done=1.
REQ-022 req=1111 held, each job acked 2 cycles after resp_valid -> grant order 0001, 0010, 0100, 1000, 0001.
REQ-023 req=0100, num=0 -> no eng_input_ready, resp_valid[2] with resp_err=1 two cycles after selection; jobs_done unchanged.
REQ-024 eng_done never asserted, TIMEOUT=255 -> eng_output_taken pulse exactly 255 cycles after BUSY entry, resp_err=1, results 0.
REQ-025 eng_done in the timeout cycle -> resp_err=0 and results captured. Wrong-index resp_ack ignored; resp_valid held.
REQ-026 reset asserted in BUSY -> next cycle: grant=0, busy=0, no pulses; after reset release, req=0010 is served normally.
